instr_encode_loader: RTL
========================

Name: instr_encode_loader

Overview:
- Sequential instruction encoder/loader: the writer for the instruction stream the main control decoder reads.
- Accepts symbolic instructions (kind plus register and immediate fields) over a valid/ready handshake.
- Encodes each into a 32-bit MIPS word (R-type ADD/SUB/AND/OR/SLT, LW, SW, BEQ, J) and writes it to instruction memory at consecutive addresses.
- Sits between the test/boot host and the imem write port.

Parameters:
- ADDR_W, 8, imem word-address width; capacity DEPTH = 2**ADDR_W words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new program load; honoured only in IDLE or DONE.
- in_valid  in  1  host presents an instruction.
- in_ready  out  1  block accepts an instruction this cycle.
- in_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 J; 9-15 invalid.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate for LW/SW/BEQ.
- in_target  in  26  jump target for J.
- in_last  in  1  marks the final instruction of the program.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since the last start.
- busy  out  1  high in RUN and WRITE.
- done  out  1  level, high in DONE until start or rst.
- err  out  1  sticky; set on an invalid kind or an overflow attempt; cleared by start or rst.

Behaviour:
- Reset: state IDLE. in_ready, imem_we, busy, done and err are 0. imem_addr = BASE_ADDR, imem_wdata = 0, count = 0.
- Mid-operation reset aborts with no further imem_we pulse.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, 5'b00000, func}, with func ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - LW: {100011, rs, rt, imm}. SW: {101011, rs, rt, imm}. BEQ: {000100, rs, rt, imm}.
  - J: {000010, target}.
  - Unused fields are ignored. in_rd is used only for R-type.
- FSM states: IDLE, RUN, WRITE, DONE.
- IDLE: in_ready = 0. start -> ptr = BASE_ADDR, count = 0, err = 0, next state RUN.
- RUN: in_ready = 1, busy = 1. On in_valid & in_ready:
  - Valid kind: latch the encoded word into imem_wdata, imem_addr = ptr, latch in_last, next state WRITE.
  - Invalid kind (9-15): err <= 1, nothing is written. Next state is DONE if in_last, otherwise stay in RUN.
- WRITE: imem_we = 1 for exactly this cycle, in_ready = 0. ptr++ and count++.
  - Next state DONE if the latched last flag is set or ptr == DEPTH-1 (memory full); otherwise RUN.
- Latency and throughput:
  - Accept to imem_we is 1 cycle.
  - Sustained throughput is 1 instruction per 2 cycles.
  - in_ready deasserts the cycle after acceptance.
- DONE: done = 1, in_ready = 0. start -> RUN with ptr, count and err re-initialised as in IDLE.
- Overflow: if the host asserts in_valid while in DONE because memory filled (not because of in_last), err <= 1 and the input is dropped.
- start is ignored in RUN and WRITE.
- ptr never wraps. The maximum count is DEPTH - BASE_ADDR.
- imem_addr and imem_wdata hold their last value outside WRITE.

Test Plan:
- ADD rs=1, rt=2, rd=3 after start -> imem_we pulse 1 cycle after accept, addr 0x00, wdata 0x00221820, count 1.
- Stream LW(rs=4, rt=5, imm=0x0010), SW(rs=0, rt=7, imm=0x0008), BEQ(rs=1, rt=2, imm=0xFFFF), J(target=0x40, in_last=1) with in_valid held high:
  - Writes 0x8C850010, 0xAC070008, 0x1022FFFF, 0x08000040 to addresses 0 to 3, one every 2 cycles.
  - Ends with done = 1, count = 4, err = 0.
- in_kind = 12 mid-stream -> err = 1, no write for that item, subsequent valid items still written at the next consecutive address.
- ADDR_W = 2, BASE_ADDR = 0, 5 instructions offered without in_last -> 4 writes (addr 0 to 3), DONE after the 4th, 5th offer sets err, in_ready stays 0.
- rst asserted in the WRITE cycle -> all outputs return to reset values the next cycle, count = 0, no further imem_we.
- start during RUN is ignored. start in DONE -> count = 0, err = 0, next write goes to BASE_ADDR.

Source files
------------

// File: rtl/instr_encode_loader_if.sv
// Host-side instruction stream: one symbolic instruction per valid/ready handshake.
// The host drives the fields as master; the loader receives them as slave.
interface instr_encode_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
        output in_ready
    );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes symbolic instructions into 32-bit MIPS words and writes them to
// consecutive imem word addresses, one write every two cycles.
module instr_encode_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    instr_encode_loader_if.slave  in_bus,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_W:0]       count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_WA = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              last_q;
    logic              full_q;   // DONE was reached by filling memory, not by in_last
    logic [31:0]       enc_word;
    logic              kind_ok;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        enc_word = 32'h0000_0000;
        kind_ok  = 1'b1;
        case (in_bus.in_kind)
            4'd0: enc_word = {6'b000000, in_bus.in_rs, in_bus.in_rt, in_bus.in_rd, 5'b00000, 6'b100000};
            4'd1: enc_word = {6'b000000, in_bus.in_rs, in_bus.in_rt, in_bus.in_rd, 5'b00000, 6'b100010};
            4'd2: enc_word = {6'b000000, in_bus.in_rs, in_bus.in_rt, in_bus.in_rd, 5'b00000, 6'b100100};
            4'd3: enc_word = {6'b000000, in_bus.in_rs, in_bus.in_rt, in_bus.in_rd, 5'b00000, 6'b100101};
            4'd4: enc_word = {6'b000000, in_bus.in_rs, in_bus.in_rt, in_bus.in_rd, 5'b00000, 6'b101010};
            4'd5: enc_word = {6'b100011, in_bus.in_rs, in_bus.in_rt, in_bus.in_imm};
            4'd6: enc_word = {6'b101011, in_bus.in_rs, in_bus.in_rt, in_bus.in_imm};
            4'd7: enc_word = {6'b000100, in_bus.in_rs, in_bus.in_rt, in_bus.in_imm};
            4'd8: enc_word = {6'b000010, in_bus.in_target};
            default: kind_ok = 1'b0;
        endcase
    end

    assign in_bus.in_ready = (state == RUN);
    assign busy            = (state == RUN) || (state == WRITE);
    assign done            = (state == DONE);
    assign imem_we         = (state == WRITE);

    // NOTE: all state uses non-blocking assignments; the synchronous reset
    // covers every register, including the held imem address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= BASE;
            count      <= '0;
            err        <= 1'b0;
            last_q     <= 1'b0;
            full_q     <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr    <= BASE;
                        count  <= '0;
                        err    <= 1'b0;
                        full_q <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (in_bus.in_valid) begin
                        if (kind_ok) begin
                            imem_wdata <= enc_word;
                            imem_addr  <= ptr;
                            last_q     <= in_bus.in_last;
                            state      <= WRITE;
                        end else begin
                            err <= 1'b1;
                            if (in_bus.in_last) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                WRITE: begin
                    count <= count + (ADDR_W + 1)'(1);
                    // At the top word the pointer is held so it can never wrap.
                    if (ptr == LAST_WA) begin
                        full_q <= ~last_q;
                        state  <= DONE;
                    end else begin
                        ptr   <= ptr + ADDR_W'(1);
                        state <= last_q ? DONE : RUN;
                    end
                end
                DONE: begin
                    if (start) begin
                        ptr    <= BASE;
                        count  <= '0;
                        err    <= 1'b0;
                        full_q <= 1'b0;
                        state  <= RUN;
                    end else if (in_bus.in_valid && full_q) begin
                        err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
